// File: rtl/cnn_run_ctrl_pkg.sv
// Shared types and constants for the CNN run controller.
package cnn_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_SHOW  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [7:0] LED_ERR = 8'hFF;
    localparam int DEF_NUM_CLASS = 10;
    localparam int DEF_SCORE_W   = 16;

endpackage

// File: rtl/cnn_run_ctrl_btn_debounce.sv
// Push-button synchroniser and debouncer.
// Emits the debounced level and a one-cycle pulse on its rising edge.
module cnn_run_ctrl_btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            btn_press <= 1'b0;
            // A sample matching the current level restarts the count.
            if (sync2 == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt       <= '0;
                btn_level <= sync2;
                btn_press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_run_ctrl.sv
// Run controller: button-triggered start, argmax over the class-score
// stream, LED result display and run watchdog.
module cnn_run_ctrl
    import cnn_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int NUM_CLASS    = DEF_NUM_CLASS,
    parameter int SCORE_W      = DEF_SCORE_W,
    parameter int TIMEOUT_CYC  = 1 << 20
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [3:0]                sw,
    input  logic                      button,
    output logic                      cnn_start,
    output logic [3:0]                cnn_img_sel,
    input  logic                      score_valid,
    input  logic signed [SCORE_W-1:0] score_data,
    input  logic                      score_last,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [7:0]                led_o
);

    localparam int CW = $clog2(NUM_CLASS);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_CLASS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    state_t                    state;
    logic signed [SCORE_W-1:0] max_score;
    logic [CW-1:0]             max_idx;
    logic [CW-1:0]             beat_cnt;
    logic [TW-1:0]             timer;
    logic                      btn_level;
    logic                      btn_press;
    logic                      start_req;
    logic                      beat_wins;
    logic [CW-1:0]             idx_next;

    cnn_run_ctrl_btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk      (clk),
        .resetn   (resetn),
        .btn_raw  (button),
        .btn_level(btn_level),
        .btn_press(btn_press)
    );

    assign start_req = btn_press & btn_level;

    // Strict compare keeps the lower index on ties.
    assign beat_wins = (beat_cnt == '0) || (score_data > max_score);
    assign idx_next  = beat_wins ? beat_cnt : max_idx;

    assign busy_o = (state == ST_START) || (state == ST_RUN);
    assign err_o  = (state == ST_ERR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            cnn_start   <= 1'b0;
            cnn_img_sel <= 4'h0;
            led_o       <= 8'h00;
            max_score   <= '0;
            max_idx     <= '0;
            beat_cnt    <= '0;
            timer       <= '0;
        end else begin
            cnn_start <= 1'b0;
            case (state)
                ST_IDLE, ST_SHOW, ST_ERR: begin
                    if (start_req) begin
                        state       <= ST_START;
                        cnn_img_sel <= sw;
                    end
                end
                ST_START: begin
                    cnn_start <= 1'b1;
                    max_score <= '0;
                    max_idx   <= '0;
                    beat_cnt  <= '0;
                    timer     <= '0;
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    if (score_valid && score_last) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state <= ST_SHOW;
                            led_o <= {cnn_img_sel, 4'(idx_next)};
                        end else begin
                            state <= ST_ERR;
                            led_o <= LED_ERR;
                        end
                    end else if (score_valid && beat_cnt == LAST_BEAT) begin
                        state <= ST_ERR;
                        led_o <= LED_ERR;
                    end else if (timer == TMO_LAST) begin
                        state <= ST_ERR;
                        led_o <= LED_ERR;
                    end else begin
                        timer <= timer + 1'b1;
                        if (score_valid) begin
                            if (beat_wins) begin
                                max_score <= score_data;
                                max_idx   <= beat_cnt;
                            end
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_run_ctrl.sv
// Randomized self-checking bench for cnn_run_ctrl against a queue-based model.
module tb_cnn_run_ctrl;

    localparam int NC = 10;
    localparam int DB = 8;
    localparam int TO = 64;
    localparam int P_IDLE = 0, P_START = 1, P_RUN = 2, P_SHOW = 3, P_ERR = 4;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [3:0]         sw = 4'h0;
    logic               button = 1'b0;
    logic               score_valid = 1'b0;
    logic signed [15:0] score_data = '0;
    logic               score_last = 1'b0;
    logic               cnn_start;
    logic [3:0]         cnn_img_sel;
    logic               busy_o;
    logic               err_o;
    logic [7:0]         led_o;

    int checks = 0;
    int passed = 0;
    bit cmp_en = 0;

    cnn_run_ctrl #(
        .DEBOUNCE_CYC(DB),
        .NUM_CLASS   (NC),
        .SCORE_W     (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sw         (sw),
        .button     (button),
        .cnn_start  (cnn_start),
        .cnn_img_sel(cnn_img_sel),
        .score_valid(score_valid),
        .score_data (score_data),
        .score_last (score_last),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .led_o      (led_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h",
                      name, $time, act, exp);
    endtask

    function automatic int argmax(input int q[$]);
        int b = 0;
        for (int i = 1; i < q.size(); i++)
            if (q[i] > q[b]) b = i;
        return b;
    endfunction

    // Behavioural model: button history, score queue, argmax at completion.
    bit       m_s1, m_s2, m_level, m_press, m_pr, m_sd;
    int       m_run, m_timer, phase;
    int       beats[$];
    bit       e_start;
    bit [3:0] e_sel;
    bit [7:0] e_led;
    bit       m_done;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_run = 0;
            m_timer = 0; phase = P_IDLE; beats.delete();
            e_start = 0; e_sel = 0; e_led = 0;
        end else begin
            m_pr = m_press;
            m_sd = m_s2;
            m_s2 = m_s1;
            m_s1 = button;
            m_press = 0;
            if (m_sd != m_level) begin
                m_run++;
                if (m_run == DB) begin
                    m_level = m_sd;
                    m_press = m_sd;
                    m_run = 0;
                end
            end else m_run = 0;
            e_start = 0;
            case (phase)
                P_IDLE, P_SHOW, P_ERR:
                    if (m_pr) begin phase = P_START; e_sel = sw; end
                P_START: begin
                    phase = P_RUN; e_start = 1; beats.delete(); m_timer = 0;
                end
                P_RUN: begin
                    m_done = 0;
                    if (score_valid) begin
                        beats.push_back(int'(score_data));
                        if (score_last) begin
                            m_done = 1;
                            if (beats.size() == NC) begin
                                phase = P_SHOW;
                                e_led = {e_sel, 4'(argmax(beats))};
                            end else begin
                                phase = P_ERR; e_led = 8'hFF;
                            end
                        end else if (beats.size() == NC) begin
                            m_done = 1; phase = P_ERR; e_led = 8'hFF;
                        end
                    end
                    if (!m_done) begin
                        if (m_timer == TO - 1) begin
                            phase = P_ERR; e_led = 8'hFF;
                        end else m_timer++;
                    end
                end
                default: phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en)
            chk("cycle",
                {cnn_start, cnn_img_sel, busy_o, err_o, led_o},
                {e_start, e_sel, (phase == P_START || phase == P_RUN),
                 (phase == P_ERR), e_led});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start(input logic [3:0] s);
        bit ok = 0;
        sw = s;
        button = 1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (cnn_start) ok = 1;
        end
        button = 0;
        chk("start_seen", 32'(ok), 1);
    endtask

    // gap: 0 none, 1 alternate idle cycles, 2 random idle cycles
    task automatic send(input int vals[$], input int last_at, input int gap);
        foreach (vals[i]) begin
            if (i > 0 && (gap == 1 || (gap == 2 && $urandom_range(1, 0) == 1)))
            begin
                score_valid = 0; score_last = 0;
                @(negedge clk);
            end
            score_valid = 1;
            score_data = 16'(vals[i]);
            score_last = (i == last_at);
            @(negedge clk);
        end
        score_valid = 0;
        score_last = 0;
    endtask

    int sc[$] = '{3, -2, 7, 1, 7, 0, -9, 4, 2, 6};
    int sh[$] = '{3, -2, 7, 1, 7, 0, -9};
    int ng[$];
    int rv[$];
    int n1, n2, cyc, extra, len;
    bit seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cmp_en = 1;
        chk("model_argmax_tie", 32'(argmax(sc)), 2);
        for (int i = 0; i < NC; i++) ng.push_back(-100 + 5 * i);
        chk("model_argmax_neg", 32'(argmax(ng)), 9);
        tick(3);
        chk("rst_start", 32'(cnn_start), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_led", 32'(led_o), 0);
        chk("rst_sel", 32'(cnn_img_sel), 0);
        resetn = 1;
        tick(12);

        // T1 bouncing button, then a clean hold
        sw = 4'h1; n1 = 0; n2 = 0;
        for (int i = 0; i < 40; i++) begin
            button = ((i / 3) % 2) == 0;
            @(negedge clk);
            if (cnn_start) n1++;
        end
        button = 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) button = 0;
            @(negedge clk);
            if (cnn_start) n2++;
        end
        chk("t1_no_start_toggle", 32'(n1), 0);
        chk("t1_one_start", 32'(n2), 1);
        tick(80);
        chk("t1_timeout_err", 32'(err_o), 1);

        // T2 normal run
        tick(12);
        press_start(4'h5);
        send(sc, 9, 0);
        tick(2);
        chk("t2_led", 32'(led_o), 32'h52);
        chk("t2_busy", 32'(busy_o), 0);
        chk("t2_err", 32'(err_o), 0);

        // T3 gapped stream
        tick(12);
        press_start(4'h5);
        send(sc, 9, 1);
        tick(2);
        chk("t3_led", 32'(led_o), 32'h52);

        // T4 short stream, then recovery
        tick(12);
        press_start(4'h7);
        send(sh, 6, 0);
        tick(2);
        chk("t4_err", 32'(err_o), 1);
        chk("t4_led", 32'(led_o), 32'hFF);
        tick(12);
        press_start(4'h3);
        send(ng, 9, 0);
        tick(2);
        chk("t4_led_rec", 32'(led_o), 32'h39);
        chk("t4_err_rec", 32'(err_o), 0);

        // T5 timeout with a press during RUN
        tick(12);
        press_start(4'h2);
        seen = 0; cyc = 0; extra = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            if (i == 5) button = 1;
            if (i == 20) button = 0;
            @(negedge clk);
            if (cnn_start) extra++;
            if (err_o) begin seen = 1; cyc = i; end
        end
        chk("t5_err_delay", 32'(cyc), 64);
        chk("t5_no_second_start", 32'(extra), 0);

        // T6 reset mid-run
        tick(12);
        press_start(4'h6);
        send(sh[0:3], -1, 0);
        @(posedge clk);
        #1 resetn = 0;
        #1;
        chk("t6_start", 32'(cnn_start), 0);
        chk("t6_busy", 32'(busy_o), 0);
        chk("t6_err", 32'(err_o), 0);
        chk("t6_led", 32'(led_o), 0);
        chk("t6_sel", 32'(cnn_img_sel), 0);
        tick(3);
        resetn = 1;
        send(sc, 9, 0);
        tick(3);
        chk("t6_led_after", 32'(led_o), 0);
        chk("t6_busy_after", 32'(busy_o), 0);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            tick(12);
            press_start(4'($urandom_range(15, 0)));
            len = ($urandom_range(4, 0) == 0) ? $urandom_range(12, 1) : NC;
            rv.delete();
            for (int i = 0; i < len; i++) begin
                if (r % 2 == 0) rv.push_back($urandom_range(6, 0) - 3);
                else rv.push_back(int'($signed(16'($urandom))));
            end
            send(rv, len - 1, 2);
            tick(3);
        end

        tick(5);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
